// File: rtl/fb_writer.sv
// fb_writer: write side of a double-buffered frame buffer.
// It accepts single-pixel writes, runs whole-buffer fills, and swaps the
// front and back buffers at a frame boundary.
// Optional feature macro: FB_COLOR_KEY_EN. When it is defined, accepted
// pixels that match COLOR_KEY are discarded. Fills always write.
module fb_writer #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          BUF_SIZE  = 307200,
  parameter logic [23:0] COLOR_KEY = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [23:0] pix_color,
  input  logic        fill_start,
  input  logic [23:0] fill_color,
  input  logic        swap_req,
  input  logic        frame_sync,
  output logic        busy,
  output logic        swap_done,
  output logic [19:0] display_offset,
  output logic [19:0] ram_address,
  output logic        ram_write_enable,
  output logic [23:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  localparam logic [19:0] BUF_W = 20'(BUF_SIZE);
  localparam logic [19:0] H_W   = 20'(H_RES);
  localparam logic [19:0] V_W   = 20'(V_RES);
`ifdef FB_COLOR_KEY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  state_t      state, state_next;
  logic        front, front_next;          // 0: buffer 0 is displayed
  logic [19:0] fill_cnt, fill_cnt_next;
  logic [23:0] fill_data, fill_data_next;
  logic [19:0] addr_next;
  logic        we_next;
  logic [23:0] data_next;
  logic        swap_done_next;

  logic [19:0] back_offset;
  logic [19:0] pix_addr;
  logic        in_range;
  logic        key_drop;

  // Pixel address decode: the product is formed at full 20-bit width, then the back offset is added.
  assign back_offset = front ? 20'd0 : BUF_W;
  assign pix_addr    = back_offset + ({10'd0, pix_y} * H_W) + {10'd0, pix_x};
  assign in_range    = ({10'd0, pix_x} < H_W) && ({10'd0, pix_y} < V_W);
  assign key_drop    = KEY_EN && (pix_color == COLOR_KEY);

  // Next-state and next-output logic for the IDLE/FILL/SWAP_WAIT controller.
  always_comb begin
    state_next     = state;
    front_next     = front;
    fill_cnt_next  = fill_cnt;
    fill_data_next = fill_data;
    addr_next      = ram_address;
    we_next        = 1'b0;
    data_next      = ram_data;
    swap_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          // The first fill word goes out in the next cycle.
          state_next     = FILL;
          fill_data_next = fill_color;
          fill_cnt_next  = 20'd1;
          addr_next      = back_offset;
          we_next        = 1'b1;
          data_next      = fill_color;
        end else if (swap_req) begin
          state_next = SWAP_WAIT;
        end else if (pix_valid && pix_ready && in_range && !key_drop) begin
          addr_next = pix_addr;
          we_next   = 1'b1;
          data_next = pix_color;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        if (fill_cnt == BUF_W) begin
          state_next = IDLE;
        end else begin
          addr_next     = back_offset + fill_cnt;
          we_next       = 1'b1;
          data_next     = fill_data;
          fill_cnt_next = fill_cnt + 20'd1;
        end
      end
      SWAP_WAIT: begin
        if (frame_sync) begin
          front_next     = ~front;
          swap_done_next = 1'b1;
          state_next     = IDLE;
        end else begin
          state_next = SWAP_WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered-output update, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      front            <= 1'b0;
      fill_cnt         <= 20'd0;
      fill_data        <= 24'd0;
      ram_address      <= 20'd0;
      ram_write_enable <= 1'b0;
      ram_data         <= 24'd0;
      swap_done        <= 1'b0;
      display_offset   <= 20'd0;
      busy             <= 1'b0;
      pix_ready        <= 1'b1;
    end else begin
      state            <= state_next;
      front            <= front_next;
      fill_cnt         <= fill_cnt_next;
      fill_data        <= fill_data_next;
      ram_address      <= addr_next;
      ram_write_enable <= we_next;
      ram_data         <= data_next;
      swap_done        <= swap_done_next;
      display_offset   <= front_next ? BUF_W : 20'd0;
      busy             <= (state_next != IDLE);
      pix_ready        <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer, with reduced resolution so fills stay short.
module tb_fb_writer;

  localparam int H   = 16;
  localparam int V   = 12;
  localparam int BUF = H * V;
`ifdef FB_COLOR_KEY_EN
  localparam bit KEY_ON = 1'b1;
`else
  localparam bit KEY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_color;
  logic        fill_start;
  logic [23:0] fill_color;
  logic        swap_req;
  logic        frame_sync;
  logic        busy;
  logic        swap_done;
  logic [19:0] display_offset;
  logic [19:0] ram_address;
  logic        ram_write_enable;
  logic [23:0] ram_data;

  int total = 0;
  int bad   = 0;
  int front_m = 0;   // reference model: which buffer is displayed

  fb_writer #(.H_RES(H), .V_RES(V), .BUF_SIZE(BUF), .COLOR_KEY(24'h000000)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .fill_start(fill_start), .fill_color(fill_color),
    .swap_req(swap_req), .frame_sync(frame_sync),
    .busy(busy), .swap_done(swap_done), .display_offset(display_offset),
    .ram_address(ram_address), .ram_write_enable(ram_write_enable), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int back_m();
    return (front_m == 0) ? BUF : 0;
  endfunction

  function automatic bit write_expected(int x, int y, logic [23:0] c);
    return (x < H) && (y < V) && !(KEY_ON && c == 24'h000000);
  endfunction

  task automatic set_pix(input logic v, input int x, input int y, input logic [23:0] c);
    pix_valid = v;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_color = c;
  endtask

  // Run a fill and check every cycle of it against the model.
  task automatic run_fill(input logic [23:0] c, input string tag);
    fill_start = 1'b1;
    fill_color = c;
    tick();
    fill_start = 1'b0;
    fill_color = 24'h0;
    for (int i = 0; i < BUF; i++) begin
      chk({tag, "_we"}, 32'(ram_write_enable), 32'd1);
      chk({tag, "_addr"}, 32'(ram_address), 32'(back_m() + i));
      chk({tag, "_data"}, 32'(ram_data), 32'(c));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
      // requests during the fill must be ignored
      set_pix(i < BUF - 1, 1, 1, 24'h123);
      swap_req   = (i == 3);
      fill_start = (i == 5);
      tick();
      swap_req   = 1'b0;
      fill_start = 1'b0;
    end
    chk({tag, "_end_we"}, 32'(ram_write_enable), 32'd0);
    chk({tag, "_end_ready"}, 32'(pix_ready), 32'd1);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_pix(1'b0, 0, 0, 24'h0);
    fill_start = 1'b0; fill_color = 24'h0; swap_req = 1'b0; frame_sync = 1'b0;
    tick(); tick();
    chk("rst_we", 32'(ram_write_enable), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd1);
    chk("rst_offset", 32'(display_offset), 32'd0);
    rst = 1'b0;

    // single pixel (3,2)
    set_pix(1'b1, 3, 2, 24'h000ABC);
    tick();
    set_pix(1'b0, 0, 0, 24'h0);
    chk("pix1_we", 32'(ram_write_enable), 32'd1);
    chk("pix1_addr", 32'(ram_address), 32'(BUF + 2 * H + 3));
    chk("pix1_data", 32'(ram_data), 32'h000ABC);
    chk("pix1_offset", 32'(display_offset), 32'd0);
    tick();
    chk("pix1_single", 32'(ram_write_enable), 32'd0);

    // back-to-back corners, then out-of-range
    set_pix(1'b1, 0, 0, 24'h000111);
    tick();
    chk("b2b0_addr", 32'(ram_address), 32'(BUF));
    chk("b2b0_we", 32'(ram_write_enable), 32'd1);
    chk("b2b0_ready", 32'(pix_ready), 32'd1);
    set_pix(1'b1, H - 1, V - 1, 24'h000222);
    tick();
    chk("b2b1_addr", 32'(ram_address), 32'(2 * BUF - 1));
    chk("b2b1_data", 32'(ram_data), 32'h000222);
    chk("b2b1_ready", 32'(pix_ready), 32'd1);
    set_pix(1'b1, H, 0, 24'h000333);
    tick();
    set_pix(1'b0, 0, 0, 24'h0);
    chk("oor_we", 32'(ram_write_enable), 32'd0);
    chk("oor_ready", 32'(pix_ready), 32'd1);

    // color key (or not) on black
    set_pix(1'b1, 1, 1, 24'h000000);
    tick();
    chk("key0_we", 32'(ram_write_enable), 32'(!KEY_ON));
    set_pix(1'b1, 1, 1, 24'h000001);
    tick();
    set_pix(1'b0, 0, 0, 24'h0);
    chk("key1_we", 32'(ram_write_enable), 32'd1);
    chk("key1_addr", 32'(ram_address), 32'(BUF + H + 1));

    // randomized pixel traffic against the model
    for (int n = 0; n < 300; n++) begin
      int x, y;
      logic v;
      logic [23:0] c;
      v = ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, H + 1);
      y = $urandom_range(0, V);
      c = ($urandom_range(0, 5) == 0) ? 24'h0 : 24'($urandom);
      set_pix(v, x, y, c);
      tick();
      chk("rnd_ready", 32'(pix_ready), 32'd1);
      if (v && write_expected(x, y, c)) begin
        chk("rnd_we", 32'(ram_write_enable), 32'd1);
        chk("rnd_addr", 32'(ram_address), 32'(back_m() + y * H + x));
        chk("rnd_data", 32'(ram_data), 32'(c));
      end else begin
        chk("rnd_nowe", 32'(ram_write_enable), 32'd0);
      end
    end
    set_pix(1'b0, 0, 0, 24'h0);
    tick();

    // fill of the back buffer
    run_fill(24'h000FFF, "fill1");
    chk("fill1_offset", 32'(display_offset), 32'd0);

    // swap: a frame_sync coinciding with the request does not count
    swap_req = 1'b1;
    frame_sync = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_sync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("sw_busy", 32'(busy), 32'd1);
      chk("sw_ready", 32'(pix_ready), 32'd0);
      chk("sw_we", 32'(ram_write_enable), 32'd0);
      chk("sw_done_low", 32'(swap_done), 32'd0);
      chk("sw_offset_hold", 32'(display_offset), 32'd0);
      set_pix(1'b1, 2, 2, 24'h456);
      fill_start = (i == 4);
      tick();
      fill_start = 1'b0;
    end
    set_pix(1'b0, 0, 0, 24'h0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    front_m = 1 - front_m;
    chk("sw_offset", 32'(display_offset), 32'(BUF));
    chk("sw_done", 32'(swap_done), 32'd1);
    chk("sw_busy_end", 32'(busy), 32'd0);
    chk("sw_ready_end", 32'(pix_ready), 32'd1);
    set_pix(1'b1, 0, 0, 24'h000777);
    tick();
    set_pix(1'b0, 0, 0, 24'h0);
    chk("sw_done_once", 32'(swap_done), 32'd0);
    chk("post_sw_we", 32'(ram_write_enable), 32'd1);
    chk("post_sw_addr", 32'(ram_address), 32'd0);

    // fill, swap and pixel together: fill wins, the rest are dropped
    set_pix(1'b1, 5, 5, 24'h000999);
    swap_req = 1'b1;
    run_fill(24'h000ABC, "fill2");
    set_pix(1'b0, 0, 0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      frame_sync = (i == 1);
      tick();
      frame_sync = 1'b0;
      chk("drop_offset", 32'(display_offset), 32'(BUF));
      chk("drop_done", 32'(swap_done), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_we", 32'(ram_write_enable), 32'd0);
    end

    // reset in the middle of a fill
    fill_start = 1'b1;
    fill_color = 24'h000555;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_we", 32'(ram_write_enable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    front_m = 0;
    chk("mrst_we", 32'(ram_write_enable), 32'd0);
    chk("mrst_addr", 32'(ram_address), 32'd0);
    chk("mrst_offset", 32'(display_offset), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(pix_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_nowrite", 32'(ram_write_enable), 32'd0);
    end
    set_pix(1'b1, 3, 2, 24'h000ABC);
    tick();
    set_pix(1'b0, 0, 0, 24'h0);
    chk("mrst_pix_addr", 32'(ram_address), 32'(BUF + 2 * H + 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
